// File: rtl/calculator_alu.sv
// calculator_alu: arithmetic responder for the calculator datapath.
// One ADD/SUB/MUL/DIV request per input handshake; registered result and
// error flag returned over a second handshake. ADD/SUB finish on the accept
// edge. MUL uses a shift-add engine and DIV a restoring divider, one bit per
// cycle.
// Optional feature macro: CALC_ALU_DIV_EN. When it is defined the iterative
// divider is built. When it is undefined DIV answers at once with result 0
// and error 1.
module calculator_alu #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_alu_input_a,
  input  logic [DATA_WIDTH-1:0] i_alu_input_b,
  input  logic [1:0]            i_alu_input_op,
  input  logic                  i_alu_input_signed,
  input  logic                  i_alu_input_valid,
  output logic                  o_alu_input_ready,
  output logic [DATA_WIDTH-1:0] o_alu_result,
  output logic                  o_alu_error,
  output logic                  o_alu_result_valid,
  input  logic                  i_alu_result_ready
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  // Control state (reset)
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     result_q;
  logic             error_q;
  logic             valid_q;

  // Operand / engine state (not reset)
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             sgn_q;
  logic             neg_q;
  logic [W-1:0]     mag_a_q;
  logic [W-1:0]     mag_b_q;
  logic [2*W-1:0]   acc_q;
`ifdef CALC_ALU_DIV_EN
  logic [1:0]       op_q;
  logic [CNT_W-1:0] div_idx;
`endif

  logic [W:0]       addsub_c;
  logic [W-1:0]     mag_a_c;
  logic [W-1:0]     mag_b_c;
  logic             neg_c;
  logic [2*W-1:0]   step0_c;
  logic [2*W-1:0]   step_c;
  logic [W:0]       fix_c;

  // {error, result} for ADD/SUB; error is carry/borrow or signed overflow
  function automatic logic [W:0] addsub(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic sub, input logic sgn);
    logic [W:0]   ext;
    logic [W-1:0] r;
    logic         ovf;
    ext = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    r   = ext[W-1:0];
    if (sgn)
      ovf = sub ? ((a[W-1] != b[W-1]) && (r[W-1] != a[W-1]))
                : ((a[W-1] == b[W-1]) && (r[W-1] != a[W-1]));
    else
      ovf = ext[W];
    return {ovf, r};
  endfunction

  // Absolute value of a signed operand; the most negative value maps to 2^(W-1)
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic sgn);
    logic signed [W-1:0] sv;
    sv = signed'(v);
    if (sgn && sv[W-1])
      return unsigned'(-sv);
    return v;
  endfunction

  // One shift-add step: add the multiplicand to the high half if the
  // multiplier bit is set, then shift the whole accumulator right by one
  function automatic logic [2*W-1:0] mul_step(input logic [W-1:0] hi, input logic [W-2:0] lo_up,
                                              input logic [W-1:0] mcand, input logic mbit);
    logic [W:0] sum;
    sum = {1'b0, hi} + {1'b0, mcand & {W{mbit}}};
    return {sum, lo_up};
  endfunction

  // {error, result} from the magnitude product: negate, then range check
  function automatic logic [W:0] mul_fix(input logic [2*W-1:0] prod, input logic sgn,
                                         input logic neg);
    logic [W-1:0] lo;
    logic         ovf;
    lo  = prod[W-1:0];
    ovf = (|prod[2*W-1:W]) ||
          (sgn && prod[W-1] && !(neg && (prod[W-2:0] == '0)));
    return {ovf, neg ? -lo : lo};
  endfunction

`ifdef CALC_ALU_DIV_EN
  // One restoring-division step: shift in the next dividend bit, subtract
  // the divisor when it fits and record the quotient bit
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] rem, input logic [W-2:0] quo,
                                              input logic dbit, input logic [W-1:0] dsor);
    logic [W:0]   part;
    logic         qbit;
    logic [W-1:0] rem_n;
    part  = {rem, dbit};
    qbit  = (part >= {1'b0, dsor});
    rem_n = qbit ? W'(part - {1'b0, dsor}) : part[W-1:0];
    return {rem_n, quo, qbit};
  endfunction

  // {error, result} from the magnitude quotient; only MIN / -1 overflows
  function automatic logic [W:0] div_fix(input logic [W-1:0] quo, input logic sgn,
                                         input logic neg);
    logic ovf;
    ovf = sgn && !neg && quo[W-1];
    return {ovf, neg ? -quo : quo};
  endfunction

  assign div_idx = CNT_W'(W-1) - cnt_q;
`endif

  assign o_alu_input_ready  = (state_q == S_IDLE);
  assign o_alu_result       = result_q;
  assign o_alu_error        = error_q;
  assign o_alu_result_valid = valid_q;

  assign addsub_c = addsub(i_alu_input_a, i_alu_input_b, i_alu_input_op[0], i_alu_input_signed);
  assign mag_a_c  = magnitude(a_q, sgn_q);
  assign mag_b_c  = magnitude(b_q, sgn_q);
  assign neg_c    = sgn_q && (a_q[W-1] ^ b_q[W-1]);

  // Engine step select: PREP performs step 0 from a cleared accumulator,
  // ITER performs steps 1..W-1
  always_comb begin
    step0_c = mul_step('0, '0, mag_a_c, mag_b_c[0]);
    step_c  = mul_step(acc_q[2*W-1:W], acc_q[W-1:1], mag_a_q, mag_b_q[cnt_q]);
    fix_c   = mul_fix(acc_q, sgn_q, neg_q);
`ifdef CALC_ALU_DIV_EN
    if (op_q == OP_DIV) begin
      step0_c = div_step('0, '0, mag_a_c[W-1], mag_b_c);
      step_c  = div_step(acc_q[2*W-1:W], acc_q[W-2:0], mag_a_q[div_idx], mag_b_q);
      fix_c   = div_fix(acc_q[W-1:0], sgn_q, neg_q);
    end
`endif
  end

  // Operand capture and iterative engine datapath
  always_ff @(posedge clk) begin
    if ((state_q == S_IDLE) && i_alu_input_valid) begin
      a_q   <= i_alu_input_a;
      b_q   <= i_alu_input_b;
      sgn_q <= i_alu_input_signed;
`ifdef CALC_ALU_DIV_EN
      op_q  <= i_alu_input_op;
`endif
    end
    if (state_q == S_PREP) begin
      mag_a_q <= mag_a_c;
      mag_b_q <= mag_b_c;
      neg_q   <= neg_c;
      acc_q   <= step0_c;
    end else if (state_q == S_ITER) begin
      acc_q   <= step_c;
    end
  end

  // Control FSM with registered result, error and valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_alu_input_valid) begin
            case (i_alu_input_op)
              OP_ADD, OP_SUB: begin
                {error_q, result_q} <= addsub_c;
                valid_q             <= 1'b1;
                state_q             <= S_DONE;
              end
              OP_MUL: state_q <= S_PREP;
              default: begin
`ifdef CALC_ALU_DIV_EN
                state_q <= S_PREP;
`else
                result_q <= '0;
                error_q  <= 1'b1;
                valid_q  <= 1'b1;
                state_q  <= S_DONE;
`endif
              end
            endcase
          end
        end
        S_PREP: begin
          cnt_q   <= CNT_W'(1);
          state_q <= S_ITER;
`ifdef CALC_ALU_DIV_EN
          if ((op_q == OP_DIV) && (b_q == '0)) begin
            result_q <= '0;
            error_q  <= 1'b1;
            valid_q  <= 1'b1;
            state_q  <= S_DONE;
          end
`endif
        end
        S_ITER: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(W-1))
            state_q <= S_FIX;
        end
        S_FIX: begin
          {error_q, result_q} <= fix_c;
          valid_q             <= 1'b1;
          state_q             <= S_DONE;
        end
        S_DONE: begin
          if (i_alu_result_ready) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
